// File: rtl/sc_pkg.sv
// Shared definitions for the deterministic stochastic-computing datapath.
// Holds the decoder state type and the default sizing of the multiplier product.
package sc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } dec_state_t;

    localparam int DSC_NUM_INPUTS = 3;
    localparam int DSC_NUM_BITS   = 6;
    localparam int DSC_OUT_WIDTH  = DSC_NUM_INPUTS * DSC_NUM_BITS;

endpackage

// File: rtl/sc_ones_accum.sv
// Saturating ones accumulator: counts inc pulses, clips at all-ones and
// flags any increment attempted at the clip value until the next clear.
module sc_ones_accum #(
    parameter int OUT_WIDTH = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 inc,
    output logic [OUT_WIDTH-1:0] q,
    output logic                 sat
);

    localparam logic [OUT_WIDTH-1:0] MAX_COUNT = '1;

    logic [OUT_WIDTH-1:0] r_q;
    logic                 r_sat;

    // Clear wins over increment so a new window always starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q   <= '0;
            r_sat <= 1'b0;
        end else if (clr) begin
            r_q   <= '0;
            r_sat <= 1'b0;
        end else if (inc) begin
            if (r_q == MAX_COUNT) begin
                r_sat <= 1'b1;
            end else begin
                r_q <= r_q + OUT_WIDTH'(1);
            end
        end
    end

    assign q   = r_q;
    assign sat = r_sat;

endmodule

// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary decoder: counts ones over a window of 2^WIN_LOG2 valid
// stream bits and hands the count out with a valid/ready handshake.
module sc_stream_decoder
    import sc_pkg::*;
#(
    parameter int WIN_LOG2  = 18,
    parameter int OUT_WIDTH = DSC_OUT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 start,
    input  logic                 sn_in,
    input  logic                 sn_valid,
    output logic [OUT_WIDTH-1:0] z,
    output logic                 z_valid,
    input  logic                 z_ready,
    output logic                 busy,
    output logic                 ov,
    output logic                 sat
);

    localparam logic [WIN_LOG2-1:0]  LAST_BIT  = '1;
    localparam logic [OUT_WIDTH-1:0] MAX_COUNT = '1;

    dec_state_t           r_state;
    logic [WIN_LOG2-1:0]  r_winCnt;
    logic [OUT_WIDTH-1:0] r_z;
    logic                 r_zValid;
    logic                 r_busy;
    logic                 r_ovPend;

    logic                 w_bitTaken;
    logic                 w_startTaken;
    logic                 w_inc;
    logic [OUT_WIDTH-1:0] w_accQ;
    logic                 w_accSat;
    logic [OUT_WIDTH-1:0] w_finalCount;

    assign w_bitTaken   = en && (r_state == COUNT) && sn_valid;
    assign w_startTaken = en && start &&
                          ((r_state == IDLE) || ((r_state == HOLD) && z_ready));
    assign w_inc        = w_bitTaken && sn_in;

    // The terminal bit lands in the accumulator on the same edge, so z is
    // loaded with the count that already includes it.
    assign w_finalCount = (sn_in && (w_accQ != MAX_COUNT)) ? w_accQ + OUT_WIDTH'(1) : w_accQ;

    sc_ones_accum #(
        .OUT_WIDTH(OUT_WIDTH)
    ) u_accum (
        .clk(clk),
        .rst(rst),
        .clr(w_startTaken),
        .inc(w_inc),
        .q  (w_accQ),
        .sat(w_accSat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_winCnt <= '0;
            r_z      <= '0;
            r_zValid <= 1'b0;
            r_busy   <= 1'b0;
            r_ovPend <= 1'b0;
        end else if (en) begin
            r_ovPend <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state  <= COUNT;
                        r_winCnt <= '0;
                        r_busy   <= 1'b1;
                    end
                end
                COUNT: begin
                    if (sn_valid) begin
                        r_winCnt <= r_winCnt + WIN_LOG2'(1);
                        if (r_winCnt == LAST_BIT) begin
                            r_state  <= HOLD;
                            r_z      <= w_finalCount;
                            r_zValid <= 1'b1;
                            r_ovPend <= 1'b1;
                            r_busy   <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (z_ready) begin
                        r_zValid <= 1'b0;
                        if (start) begin
                            r_state  <= COUNT;
                            r_winCnt <= '0;
                            r_busy   <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // A completion pulse raised just before en drops stays pending and shows up
    // on the first enabled cycle instead of leaking out while frozen.
    assign ov      = r_ovPend && en;
    assign z       = r_z;
    assign z_valid = r_zValid;
    assign busy    = r_busy;
    assign sat     = w_accSat;

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Self-checking bench: two decoders (5-bit and 4-bit result) share one stream
// and are compared each cycle against a window-level reference model.
module tb_sc_stream_decoder;

    localparam int WL      = 4;
    localparam int WIN_LEN = 1 << WL;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0, start = 1'b0, sn_in = 1'b0, sn_valid = 1'b0, z_ready = 1'b0;
    logic [4:0] z5;
    logic [3:0] z4;
    logic       zValid5, busy5, ov5, sat5;
    logic       zValid4, busy4, ov4, sat4;

    int    passCount  = 0;
    int    checkCount = 0;
    string phase      = "reset";

    // Reference model state: which part of the window life cycle we are in,
    // the bits accepted in the current/last window, and the last reported count.
    bit mCounting, mHolding, mOvPend;
    int mResult;
    bit winBits[$];

    always #5 clk = ~clk;

    sc_stream_decoder #(.WIN_LOG2(WL), .OUT_WIDTH(5)) dut5 (
        .clk(clk), .rst(rst), .en(en), .start(start), .sn_in(sn_in), .sn_valid(sn_valid),
        .z(z5), .z_valid(zValid5), .z_ready(z_ready), .busy(busy5), .ov(ov5), .sat(sat5)
    );

    sc_stream_decoder #(.WIN_LOG2(WL), .OUT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .start(start), .sn_in(sn_in), .sn_valid(sn_valid),
        .z(z4), .z_valid(zValid4), .z_ready(z_ready), .busy(busy4), .ov(ov4), .sat(sat4)
    );

    function automatic int onesIn();
        int s = 0;
        foreach (winBits[i]) s += int'(winBits[i]);
        return s;
    endfunction

    function automatic int clip(input int v, input int maxVal);
        return (v > maxVal) ? maxVal : v;
    endfunction

    function automatic void modelReset();
        mCounting = 1'b0;
        mHolding  = 1'b0;
        mOvPend   = 1'b0;
        mResult   = 0;
        winBits.delete();
    endfunction

    // Applies one enabled clock edge using the inputs currently driven.
    function automatic void modelEdge();
        if (rst || !en) return;
        mOvPend = 1'b0;
        if (mCounting) begin
            if (sn_valid) begin
                winBits.push_back(sn_in);
                if (winBits.size() == WIN_LEN) begin
                    mCounting = 1'b0;
                    mHolding  = 1'b1;
                    mResult   = onesIn();
                    mOvPend   = 1'b1;
                end
            end
        end else if (mHolding) begin
            if (z_ready) begin
                mHolding = 1'b0;
                if (start) begin
                    mCounting = 1'b1;
                    winBits.delete();
                end
            end
        end else if (start) begin
            mCounting = 1'b1;
            winBits.delete();
        end
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic checkOutput();
        checkVal({phase, ".z5"},      32'(z5),      32'(clip(mResult, 31)));
        checkVal({phase, ".z4"},      32'(z4),      32'(clip(mResult, 15)));
        checkVal({phase, ".zValid5"}, 32'(zValid5), 32'(mHolding));
        checkVal({phase, ".zValid4"}, 32'(zValid4), 32'(mHolding));
        checkVal({phase, ".busy5"},   32'(busy5),   32'(mCounting));
        checkVal({phase, ".busy4"},   32'(busy4),   32'(mCounting));
        checkVal({phase, ".ov5"},     32'(ov5),     32'(mOvPend && en));
        checkVal({phase, ".ov4"},     32'(ov4),     32'(mOvPend && en));
        checkVal({phase, ".sat5"},    32'(sat5),    32'(onesIn() > 31));
        checkVal({phase, ".sat4"},    32'(sat4),    32'(onesIn() > 15));
    endtask

    // Lets the previous drive take its edge, then drives the next cycle's
    // inputs and checks the outputs in the low phase of the clock.
    task automatic applyStimulus(input bit st, input bit si, input bit sv, input bit zr, input bit e);
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        start = st; sn_in = si; sn_valid = sv; z_ready = zr; en = e;
        #1;
        checkOutput();
    endtask

    task automatic asyncReset();
        #1 rst = 1'b1;
        #1;
        modelReset();
        checkOutput();
        #1 rst = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        modelReset();
        checkOutput();
        #1 rst = 1'b0;

        // Alternating stream, sn_in asserted during the start cycle.
        phase = "alt";
        applyStimulus(1, 1, 1, 0, 1);
        for (int i = 0; i < WIN_LEN; i++) applyStimulus(0, (i % 2) == 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);
        checkVal("alt.ovPulse", 32'(ov5), 32'd1);
        checkVal("alt.z",       32'(z5),  32'd8);
        checkVal("alt.sat",     32'(sat5), 32'd0);
        applyStimulus(0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 1);
        checkVal("alt.zValidDrop", 32'(zValid5), 32'd0);
        checkVal("alt.zKept",      32'(z5),      32'd8);

        // Stall of five cycles after bit 7 with sn_in high.
        phase = "stall";
        applyStimulus(1, 0, 0, 0, 1);
        for (int i = 0; i < 7; i++) applyStimulus(0, (i % 2) == 0, 1, 0, 1);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0, 1);
        for (int i = 7; i < WIN_LEN; i++) applyStimulus(0, (i % 2) == 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);
        checkVal("stall.z",  32'(z5),  32'd8);
        checkVal("stall.ov", 32'(ov5), 32'd1);
        applyStimulus(0, 0, 0, 1, 1);

        // All ones: clips in the 4-bit decoder only.
        phase = "sat";
        applyStimulus(1, 0, 0, 0, 1);
        for (int i = 0; i < WIN_LEN; i++) applyStimulus(0, 1, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);
        checkVal("sat.z4",   32'(z4),   32'd15);
        checkVal("sat.sat4", 32'(sat4), 32'd1);
        checkVal("sat.z5",   32'(z5),   32'd16);
        checkVal("sat.sat5", 32'(sat5), 32'd0);

        // Backpressure with start ignored, then back-to-back window of zeros.
        phase = "hold";
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 1, 1, 0, 1);
            checkVal("hold.zStable",   32'(z5),      32'd16);
            checkVal("hold.zValid",    32'(zValid5), 32'd1);
            checkVal("hold.satStable", 32'(sat4),    32'd1);
        end
        applyStimulus(1, 0, 0, 1, 1);
        phase = "b2b";
        applyStimulus(0, 0, 1, 0, 1);
        checkVal("b2b.busy",   32'(busy5),   32'd1);
        checkVal("b2b.zValid", 32'(zValid5), 32'd0);
        for (int i = 1; i < WIN_LEN; i++) applyStimulus(0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);
        checkVal("b2b.z",    32'(z5),   32'd0);
        checkVal("b2b.sat4", 32'(sat4), 32'd0);
        applyStimulus(0, 0, 0, 1, 1);

        // Abort by reset after 7 bits, then a clean all-ones window.
        phase = "abort";
        applyStimulus(1, 0, 0, 0, 1);
        for (int i = 0; i < 7; i++) applyStimulus(0, 1, 1, 0, 1);
        asyncReset();
        checkVal("abort.busy", 32'(busy5), 32'd0);
        checkVal("abort.z",    32'(z5),    32'd0);
        applyStimulus(1, 0, 0, 0, 1);
        for (int i = 0; i < WIN_LEN; i++) applyStimulus(0, 1, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);
        checkVal("abort.zFresh", 32'(z5), 32'd16);
        applyStimulus(0, 0, 0, 1, 1);

        // Freeze for three cycles mid-window, then hold a pending ov under en=0.
        phase = "freeze";
        applyStimulus(1, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) applyStimulus(0, 1, 1, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 1, 0);
        for (int i = 8; i < WIN_LEN; i++) applyStimulus(0, 1, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkVal("freeze.ovMasked", 32'(ov5),     32'd0);
        checkVal("freeze.zValid",   32'(zValid5), 32'd1);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);
        checkVal("freeze.ovPending", 32'(ov5), 32'd1);
        checkVal("freeze.z",         32'(z5),  32'd16);
        applyStimulus(0, 0, 0, 1, 1);

        // Random traffic: starts, stalls, freezes and backpressure mixed.
        phase = "rand";
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 9) < 3, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 9) < 9);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
